// File: rtl/idiv_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Optional build macro IDIV_SIGNED_EN: two's-complement operands (magnitude divide + sign fix).
module idiv_seq #(
  parameter int SIZE = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [SIZE-1:0] iDividend,
  input  logic [SIZE-1:0] iDivisor,
  output logic [SIZE-1:0] oQuotient,
  output logic [SIZE-1:0] oRemainder,
  output logic            oBusy,
  output logic            oDone,
  output logic            oDivByZero
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [SIZE-1:0] acc_r;
  logic [SIZE-1:0] shreg_r;
  logic [SIZE-1:0] divisor_r;
  logic [CW-1:0]   cnt_r;
  logic [SIZE-1:0] quotient_r;
  logic [SIZE-1:0] remainder_r;
  logic            busy_r;
  logic            done_r;
  logic            div0_r;
  logic            dz_pend_r;

  logic [SIZE-1:0] dvd_mag_s;
  logic [SIZE-1:0] dvs_mag_s;
  logic            div0_s;
  logic [SIZE-1:0] trial_s;
  logic            qbit_s;
  logic [SIZE-1:0] acc_next_s;
  logic [SIZE-1:0] q_next_s;
  logic [SIZE-1:0] q_fin_s;
  logic [SIZE-1:0] r_fin_s;

`ifdef IDIV_SIGNED_EN
  logic dvd_neg_s;
  logic dvs_neg_s;
  logic neg_q_r;
  logic neg_r_r;
`endif

  // Operand preparation: magnitudes to feed the unsigned core
  always_comb begin
`ifdef IDIV_SIGNED_EN
    dvd_neg_s = iDividend[SIZE-1];
    dvs_neg_s = iDivisor[SIZE-1];
    if (dvd_neg_s) begin
      dvd_mag_s = ~iDividend + SIZE'(1);
    end else begin
      dvd_mag_s = iDividend;
    end
    if (dvs_neg_s) begin
      dvs_mag_s = ~iDivisor + SIZE'(1);
    end else begin
      dvs_mag_s = iDivisor;
    end
`else
    dvd_mag_s = iDividend;
    dvs_mag_s = iDivisor;
`endif
    div0_s = (iDivisor == {SIZE{1'b0}});
  end

  // One restoring step. acc < divisor, so when acc's MSB is set the full
  // SIZE+1-bit trial exceeds the divisor and the modular SIZE-bit difference is exact.
  always_comb begin
    trial_s = {acc_r[SIZE-2:0], shreg_r[SIZE-1]};
    qbit_s  = acc_r[SIZE-1] || (trial_s >= divisor_r);
    if (qbit_s) begin
      acc_next_s = trial_s - divisor_r;
    end else begin
      acc_next_s = trial_s;
    end
    q_next_s = {shreg_r[SIZE-2:0], qbit_s};
  end

  // Sign correction applied on the result edge
  always_comb begin
`ifdef IDIV_SIGNED_EN
    if (neg_q_r) begin
      q_fin_s = ~q_next_s + SIZE'(1);
    end else begin
      q_fin_s = q_next_s;
    end
    if (neg_r_r) begin
      r_fin_s = ~acc_next_s + SIZE'(1);
    end else begin
      r_fin_s = acc_next_s;
    end
`else
    q_fin_s = q_next_s;
    r_fin_s = acc_next_s;
`endif
  end

  // Control FSM and datapath registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      acc_r       <= {SIZE{1'b0}};
      shreg_r     <= {SIZE{1'b0}};
      divisor_r   <= {SIZE{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient_r  <= {SIZE{1'b0}};
      remainder_r <= {SIZE{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div0_r      <= 1'b0;
      dz_pend_r   <= 1'b0;
`ifdef IDIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          // A zero divisor spends one cycle in IDLE so its result lands one edge after accept
          if (dz_pend_r) begin
            dz_pend_r   <= 1'b0;
            quotient_r  <= {SIZE{1'b1}};
            remainder_r <= shreg_r;
            div0_r      <= 1'b1;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else if (iStart) begin
            div0_r    <= 1'b0;
            divisor_r <= dvs_mag_s;
            acc_r     <= {SIZE{1'b0}};
            cnt_r     <= CW'(SIZE - 1);
            if (div0_s) begin
              shreg_r   <= iDividend;
              dz_pend_r <= 1'b1;
              state_r   <= IDLE;
            end else begin
              shreg_r <= dvd_mag_s;
              busy_r  <= 1'b1;
              state_r <= RUN;
`ifdef IDIV_SIGNED_EN
              neg_q_r <= dvd_neg_s ^ dvs_neg_s;
              neg_r_r <= dvd_neg_s;
`endif
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          shreg_r <= q_next_s;
          cnt_r   <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            quotient_r  <= q_fin_s;
            remainder_r <= r_fin_s;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          dz_pend_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign oQuotient  = quotient_r;
  assign oRemainder = remainder_r;
  assign oBusy      = busy_r;
  assign oDone      = done_r;
  assign oDivByZero = div0_r;

endmodule

// File: tb/tb_idiv_seq.sv
// Directed self-checking bench for idiv_seq (SIZE=16); signed vectors when IDIV_SIGNED_EN is defined.
module tb_idiv_seq;

  localparam int SIZE = 16;

  logic            Clock = 1'b0;
  logic            Reset;
  logic            iStart;
  logic [SIZE-1:0] iDividend;
  logic [SIZE-1:0] iDivisor;
  logic [SIZE-1:0] oQuotient;
  logic [SIZE-1:0] oRemainder;
  logic            oBusy;
  logic            oDone;
  logic            oDivByZero;

  int total = 0;
  int bad   = 0;

  idiv_seq #(.SIZE(SIZE)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oDivByZero (oDivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called #1 after an edge; start is sampled on the next rising edge
  task automatic go(input logic [SIZE-1:0] dvd, input logic [SIZE-1:0] dvs);
    iStart    = 1'b1;
    iDividend = dvd;
    iDivisor  = dvs;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
  endtask

  // Counts edges after accept until oDone; inj>0 pulses a bogus start mid-run
  task automatic wait_done(input int lat, input int inj);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    chk("busy_at_accept", {31'd0, oBusy}, (lat > 1) ? 32'd1 : 32'd0);
    chk("dz_clear_at_accept", {31'd0, oDivByZero}, 32'd0);
    while (!seen && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
      if (inj > 0) begin
        if (n == inj) begin
          iStart    = 1'b1;
          iDividend = 16'd7;
          iDivisor  = 16'd7;
        end else begin
          iStart = 1'b0;
        end
      end
      if (oDone) begin
        seen = 1'b1;
      end else begin
        chk("busy_running", {31'd0, oBusy}, (lat > 1) ? 32'd1 : 32'd0);
      end
    end
    chk("latency", n, lat);
    chk("busy_at_done", {31'd0, oBusy}, 32'd0);
  endtask

  initial begin
    bit seen;
    Reset     = 1'b0;
    iStart    = 1'b0;
    iDividend = 16'd0;
    iDivisor  = 16'd0;
    #2;
    chk("rst_q", oQuotient, 32'd0);
    chk("rst_r", oRemainder, 32'd0);
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    chk("rst_dz", {31'd0, oDivByZero}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    go(16'd100, 16'd7);
    wait_done(16, 0);
    chk("100/7 q", oQuotient, 32'd14);
    chk("100/7 r", oRemainder, 32'd2);
    chk("100/7 dz", {31'd0, oDivByZero}, 32'd0);
    repeat (3) begin
      @(posedge Clock);
      #1;
    end
    chk("hold q", oQuotient, 32'd14);
    chk("hold r", oRemainder, 32'd2);
    chk("hold done", {31'd0, oDone}, 32'd0);

    go(16'hFFFF, 16'd1);
    wait_done(16, 0);
    chk("ffff/1 q", oQuotient, 32'hFFFF);
    chk("ffff/1 r", oRemainder, 32'd0);
    @(posedge Clock);
    #1;

    go(16'd3, 16'hFFFF);
    wait_done(16, 0);
`ifdef IDIV_SIGNED_EN
    chk("3/ffff q", oQuotient, 32'hFFFD);
    chk("3/ffff r", oRemainder, 32'd0);
`else
    chk("3/ffff q", oQuotient, 32'd0);
    chk("3/ffff r", oRemainder, 32'd3);
`endif
    @(posedge Clock);
    #1;

    go(16'd5, 16'd0);
    wait_done(1, 0);
    chk("5/0 q", oQuotient, 32'hFFFF);
    chk("5/0 r", oRemainder, 32'd5);
    chk("5/0 dz", {31'd0, oDivByZero}, 32'd1);
    @(posedge Clock);
    #1;

    go(16'd1000, 16'd10);
    wait_done(16, 5);
    chk("1000/10 q", oQuotient, 32'd100);
    chk("1000/10 r", oRemainder, 32'd0);
    go(16'd50, 16'd6);
    chk("b2b hold q", oQuotient, 32'd100);
    wait_done(16, 0);
    chk("50/6 q", oQuotient, 32'd8);
    chk("50/6 r", oRemainder, 32'd2);
    @(posedge Clock);
    #1;

    go(16'd200, 16'd3);
    repeat (5) begin
      @(posedge Clock);
      #1;
    end
    Reset = 1'b0;
    #1;
    chk("abort q", oQuotient, 32'd0);
    chk("abort r", oRemainder, 32'd0);
    chk("abort busy", {31'd0, oBusy}, 32'd0);
    chk("abort done", {31'd0, oDone}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock);
      #1;
      if (oDone || oBusy) seen = 1'b1;
    end
    chk("abort idle", {31'd0, seen}, 32'd0);

    go(16'd81, 16'd9);
    wait_done(16, 0);
    chk("81/9 q", oQuotient, 32'd9);
    chk("81/9 r", oRemainder, 32'd0);
    @(posedge Clock);
    #1;

`ifdef IDIV_SIGNED_EN
    go(16'hFF9C, 16'd7);
    wait_done(16, 0);
    chk("-100/7 q", oQuotient, 32'hFFF2);
    chk("-100/7 r", oRemainder, 32'hFFFE);
    @(posedge Clock);
    #1;
    go(16'h8000, 16'hFFFF);
    wait_done(16, 0);
    chk("min/-1 q", oQuotient, 32'h8000);
    chk("min/-1 r", oRemainder, 32'd0);
    @(posedge Clock);
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
